// File: rtl/fruit_pkg.sv
// Shared definitions for the fruit object pool.
//   - slot_state_e : per-slot lifecycle states
//   - parameter defaults for object_pool_ctrl / obj_slot_fsm
//   - SpriteTable  : 8-entry sprite base address table (two sprites alternating)
//   - screen and object geometry constants
//   - sat_add16    : saturating 16-bit counter increment
package fruit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StLaunch,
    StFly,
    StSplit,
    StFall
  } slot_state_e;

  // Parameter defaults
  localparam int unsigned NSlotsDef   = 4;
  localparam int unsigned PosWDef     = 10;
  localparam int unsigned AddrWDef    = 18;
  localparam int unsigned MinDelayDef = 16;

  // Screen and object geometry
  localparam int unsigned ScreenW = 640;
  localparam int unsigned ScreenH = 480;
  localparam int unsigned ObjW    = 100;
  localparam int unsigned ObjH    = 80;

  // Sprite base addresses, indexed by a 3-bit random field
  localparam logic [17:0] SpriteTable [8] = '{
    18'd26000, 18'd18000, 18'd26000, 18'd18000,
    18'd26000, 18'd18000, 18'd26000, 18'd18000
  };

  // Add a small per-cycle event count to a 16-bit counter, clamping at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/obj_slot_fsm.sv
// One fruit slot: lifecycle FSM, respawn delay counter and launch parameter latch.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   tick              one-cycle move-tick pulse (paces the respawn delay)
//   rand_in           free-running random word, sampled on IDLE and on grant
//   grant             launch grant from the pool arbiter
//   slice_hit         blade-hit level (only acted on in FLY)
//   oob_a, oob_b      out-of-bounds flags of the two half motion units
//   req               launch request (WAIT with delay expired)
//   miss_evt          fruit left the screen unsliced this cycle
//   load, split       one-cycle strobes to the motion units
//   active            slot is on screen
//   init_x/vx/vy/dx   latched launch parameters
//   sprite_addr       latched sprite base address
module obj_slot_fsm import fruit_pkg::*; #(
  parameter int unsigned POS_W     = PosWDef,
  parameter int unsigned ADDR_W    = AddrWDef,
  parameter int unsigned MIN_DELAY = MinDelayDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [15:0]       rand_in,
  input  logic              grant,
  input  logic              slice_hit,
  input  logic              oob_a,
  input  logic              oob_b,
  output logic              req,
  output logic              miss_evt,
  output logic              load,
  output logic              split,
  output logic              active,
  output logic [POS_W-1:0]  init_x,
  output logic [POS_W-1:0]  init_vx,
  output logic [POS_W-1:0]  init_vy,
  output logic              init_dx,
  output logic [ADDR_W-1:0] sprite_addr
);

  // Wide enough for MIN_DELAY plus the largest 6-bit random offset.
  localparam int unsigned CntW = $clog2(MIN_DELAY + 64);

  slot_state_e       state_q;
  logic [CntW-1:0]   cnt_q;
  logic              load_q;
  logic              split_q;
  logic              active_q;
  logic [POS_W-1:0]  x_q;
  logic [POS_W-1:0]  vx_q;
  logic [POS_W-1:0]  vy_q;
  logic              dx_q;
  logic [ADDR_W-1:0] addr_q;

  logic unused_rand;
  assign unused_rand = rand_in[15];

  assign req      = (state_q == StWait) && (cnt_q == '0);
  // Out-of-bounds wins over a simultaneous hit, so this alone decides a miss.
  assign miss_evt = (state_q == StFly) && (oob_a || oob_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      split_q  <= 1'b0;
      active_q <= 1'b0;
      x_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      dx_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      load_q  <= 1'b0;
      split_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q   <= CntW'(MIN_DELAY) + CntW'(rand_in[5:0]);
          state_q <= StWait;
        end
        StWait: begin
          if (grant && req) begin
            x_q      <= POS_W'({rand_in[4:0], 4'b0000});
            vx_q     <= POS_W'(rand_in[7:5]);
            vy_q     <= POS_W'(4'd6 + {1'b0, rand_in[10:8]});
            dx_q     <= rand_in[11];
            addr_q   <= ADDR_W'(SpriteTable[rand_in[14:12]]);
            load_q   <= 1'b1;
            active_q <= 1'b1;
            state_q  <= StLaunch;
          end else if (tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StLaunch: begin
          state_q <= StFly;
        end
        StFly: begin
          if (oob_a || oob_b) begin
            active_q <= 1'b0;
            state_q  <= StIdle;
          end else if (slice_hit) begin
            split_q <= 1'b1;
            state_q <= StSplit;
          end
        end
        StSplit: begin
          state_q <= StFall;
        end
        StFall: begin
          // Both halves must have left the screen.
          if (oob_a && oob_b) begin
            active_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign load        = load_q;
  assign split       = split_q;
  assign active      = active_q;
  assign init_x      = x_q;
  assign init_vx     = vx_q;
  assign init_vy     = vy_q;
  assign init_dx     = dx_q;
  assign sprite_addr = addr_q;

endmodule

// File: rtl/object_pool_ctrl.sv
// Fruit object pool controller: N_SLOTS independent slot FSMs sharing one
// round-robin launch arbiter, plus score/miss counters.
// Build option: define OBJECT_POOL_SCORE_EN to enable the score/misses counters;
// otherwise both outputs are tied to 0 and no counter logic exists.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tick                     one-cycle move-tick pulse
//   rand_in                  free-running random word
//   slice_hit                per-slot blade-hit level
//   oob_a, oob_b             per-slot out-of-bounds from the two half motion units
//   load, split              per-slot one-cycle strobes
//   init_x/init_vx/init_vy   packed per-slot launch parameters (POS_W each)
//   init_dx                  per-slot launch x-direction
//   sprite_addr              packed per-slot sprite base address (ADDR_W each)
//   active                   per-slot on-screen flag
//   score, misses            saturating 16-bit event counters
module object_pool_ctrl import fruit_pkg::*; #(
  parameter int unsigned N_SLOTS   = NSlotsDef,
  parameter int unsigned POS_W     = PosWDef,
  parameter int unsigned ADDR_W    = AddrWDef,
  parameter int unsigned MIN_DELAY = MinDelayDef
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [15:0]               rand_in,
  input  logic [N_SLOTS-1:0]        slice_hit,
  input  logic [N_SLOTS-1:0]        oob_a,
  input  logic [N_SLOTS-1:0]        oob_b,
  output logic [N_SLOTS-1:0]        load,
  output logic [N_SLOTS-1:0]        split,
  output logic [N_SLOTS*POS_W-1:0]  init_x,
  output logic [N_SLOTS*POS_W-1:0]  init_vx,
  output logic [N_SLOTS*POS_W-1:0]  init_vy,
  output logic [N_SLOTS-1:0]        init_dx,
  output logic [N_SLOTS*ADDR_W-1:0] sprite_addr,
  output logic [N_SLOTS-1:0]        active,
  output logic [15:0]               score,
  output logic [15:0]               misses
);

  localparam int unsigned PtrW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  logic [N_SLOTS-1:0] req;
  logic [N_SLOTS-1:0] grant;
  logic [N_SLOTS-1:0] miss_evt;
  logic [PtrW-1:0]    ptr_q;
  logic [PtrW-1:0]    gnt_idx;
  logic               gnt_any;

  for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
    obj_slot_fsm #(
      .POS_W     (POS_W),
      .ADDR_W    (ADDR_W),
      .MIN_DELAY (MIN_DELAY)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .rand_in     (rand_in),
      .grant       (grant[s]),
      .slice_hit   (slice_hit[s]),
      .oob_a       (oob_a[s]),
      .oob_b       (oob_b[s]),
      .req         (req[s]),
      .miss_evt    (miss_evt[s]),
      .load        (load[s]),
      .split       (split[s]),
      .active      (active[s]),
      .init_x      (init_x[s*POS_W +: POS_W]),
      .init_vx     (init_vx[s*POS_W +: POS_W]),
      .init_vy     (init_vy[s*POS_W +: POS_W]),
      .init_dx     (init_dx[s]),
      .sprite_addr (sprite_addr[s*ADDR_W +: ADDR_W])
    );
  end

  // Round-robin: scan from ptr_q upward, first requester wins this cycle.
  always_comb begin : p_arb
    logic [PtrW-1:0] idx;
    grant   = '0;
    gnt_idx = ptr_q;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      idx = PtrW'((32'(ptr_q) + k) % N_SLOTS);
      if (!gnt_any && req[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Pointer moves just past the granted slot so it gets lowest priority next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == PtrW'(N_SLOTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

`ifdef OBJECT_POOL_SCORE_EN
  logic [15:0] score_q;
  logic [15:0] misses_q;
  logic [3:0]  split_cnt;
  logic [3:0]  miss_cnt;

  // Several slots may score or miss in one cycle; every event counts.
  always_comb begin
    split_cnt = '0;
    miss_cnt  = '0;
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      split_cnt = split_cnt + 4'(split[k]);
      miss_cnt  = miss_cnt + 4'(miss_evt[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      score_q  <= sat_add16(score_q, split_cnt);
      misses_q <= sat_add16(misses_q, miss_cnt);
    end
  end

  assign score  = score_q;
  assign misses = misses_q;
`else
  logic unused_miss;
  assign unused_miss = ^miss_evt;
  assign score       = '0;
  assign misses      = '0;
`endif

endmodule

// File: doc/object_pool_ctrl.md
OBJECT_POOL_CTRL -- requirements
Module: object_pool_ctrl

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4, number of independent fruit slots (1..8).
REQ-002 SHALL have parameter POS_W, default 10, position/velocity field width.
REQ-003 SHALL have parameter ADDR_W, default 18, sprite ROM address width.
REQ-004 SHALL have parameter MIN_DELAY, default 16, minimum respawn delay in ticks.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports named as the codebase does.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port tick, input, 1, one-cycle move-tick pulse.
REQ-009 SHALL have port rand_in, input, 16, free-running random word.
REQ-010 SHALL have port slice_hit, input, N_SLOTS, per-slot blade-hit level.
REQ-011 SHALL have port oob_a/oob_b, input, N_SLOTS each, per-slot out-of-bounds from the two half motion units.
REQ-012 SHALL have port load, output, N_SLOTS, one-cycle launch strobe to motion units.
REQ-013 SHALL have port split, output, N_SLOTS, one-cycle split strobe (halves diverge: half A dx=0, half B dx=1, vx=1, vy=0).
REQ-014 SHALL have port init_x/init_vx/init_vy, output, N_SLOTS*POS_W each, packed launch parameters.
REQ-015 SHALL have port init_dx, output, N_SLOTS, launch x-direction.
REQ-016 SHALL have port sprite_addr, output, N_SLOTS*ADDR_W, sprite base address.
REQ-017 SHALL have port active, output, N_SLOTS, slot on screen (LAUNCH/FLY/SPLIT/FALL).
REQ-018 SHALL have port score/misses, output, 16 each, counters (see Configuration).

Function
REQ-019 SHALL run per-slot FSM: IDLE, WAIT, LAUNCH, FLY, SPLIT, FALL.
REQ-020 IDLE SHALL load delay counter with MIN_DELAY + rand_in[5:0] and go to WAIT next cycle.
REQ-021 WAIT SHALL decrement the counter on tick only, and raise a launch request when it is 0.
REQ-022 Launch requests SHALL be granted one per cycle by round-robin, pointer advancing past the granted slot; ungranted slots hold in WAIT at 0.
REQ-023 Grant SHALL latch parameters: init_x = rand_in[4:0]*16, init_vx = rand_in[7:5], init_vy = 6 + rand_in[10:8], init_dx = rand_in[11], sprite_addr = table[rand_in[14:12]]; zero-extended to POS_W.
REQ-024 LAUNCH SHALL assert load for exactly one cycle, then go to FLY.
REQ-025 FLY: oob_a|oob_b SHALL go to IDLE and increment misses; else slice_hit SHALL go to SPLIT; oob takes priority when both occur in the same cycle.
REQ-026 SPLIT SHALL assert split for exactly one cycle, increment score, then go to FALL.
REQ-027 FALL SHALL go to IDLE only when oob_a&oob_b.
REQ-028 slice_hit outside FLY SHALL be ignored; latched parameters SHALL hold until the next grant.
REQ-029 score and misses SHALL saturate at 16'hFFFF; simultaneous increments from several slots SHALL all count (sum per cycle).

Reset
REQ-030 rst SHALL force all slots to IDLE, the round-robin pointer to 0, load/split/active to 0, all init_* and sprite_addr to 0, and score/misses to 0, asynchronously.
REQ-031 After rst deasserts, every slot SHALL reach WAIT within 2 cycles.

Configuration
REQ-032 With OBJECT_POOL_SCORE_EN defined, score and misses SHALL count per REQ-025/026/029.
REQ-033 Without OBJECT_POOL_SCORE_EN, score and misses SHALL be constant 0 and the counter logic SHALL be absent; the FSM is unchanged.

Structure
REQ-034 Package fruit_pkg SHALL hold: the slot-state enum; the 8-entry sprite address table (26000, 18000 alternating); the parameter defaults; and screen constants (640x480, object 100x80).
REQ-035 Per-slot FSM, delay counter and parameter latch SHALL be sub-module obj_slot_fsm, instantiated N_SLOTS times; the arbiter and counters SHALL be in the top level.

Verification
REQ-036 rst release, rand_in=0, 16 ticks -> slot 0 load at tick 16 with init_x=0, vx=0, vy=6, dx=0, sprite_addr=26000.
REQ-037 All four slots reach 0 in the same cycle -> load pulses in four consecutive cycles in round-robin order, each exactly 1 cycle wide.
REQ-038 FLY with slice_hit=1 -> split 1 cycle, score+1; then oob_a alone -> remains FALL; oob_a&oob_b -> IDLE.
REQ-039 FLY with slice_hit and oob_a in the same cycle -> no split, misses+1, slot IDLE.
REQ-040 rst asserted mid-FALL -> all outputs 0 immediately, no clock edge needed; score preset near 16'hFFFF then saturates at 16'hFFFF; without the macro, score stays 0.
